// File: rtl/csr_degree_streamer.sv
// rtl/csr_degree_streamer.sv - CSR row-pointer to per-node degree streamer (optional stats: CSR_DEGREE_STATS_EN)
module csr_degree_streamer #(
    parameter int DATA_W = 32,
    parameter int NODE_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NODE_W-1:0] num_nodes,
    input  logic [DATA_W-1:0] rp_data,
    input  logic              rp_valid,
    output logic              rp_ready,
    output logic [NODE_W-1:0] out_node_id,
    output logic [DATA_W-1:0] out_degree,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err_nonmono,
    output logic [DATA_W-1:0] max_degree,
    output logic [NODE_W-1:0] max_node_id
);

    typedef enum logic [2:0] {IDLE, FIRST, RUN, FLUSH, FIN} state_t;

    state_t            state, state_nxt;
    logic [NODE_W-1:0] target;
    logic [NODE_W-1:0] node_cnt;
    logic [DATA_W-1:0] prev;
    logic              rp_hs;
    logic              out_hs;
    logic              load;
    logic              start_acc;
    logic              nonmono;
    logic [DATA_W-1:0] beat_degree;

    assign rp_hs       = rp_valid && rp_ready;
    assign out_hs      = out_valid && out_ready;
    assign load        = (state == RUN) && rp_hs;
    assign start_acc   = (state == IDLE) && start;
    // A decreasing row pointer is flagged and reported as zero degree rather than a huge wrapped value
    assign nonmono     = rp_data < prev;
    assign beat_degree = nonmono ? '0 : rp_data - prev;
    assign busy        = state != IDLE;
    assign done        = state == FIN;

    always_comb begin
        state_nxt = state;
        rp_ready  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = FIRST;
            FIRST: begin
                rp_ready = 1'b1;
                if (rp_valid) state_nxt = (target == '0) ? FIN : RUN;
            end
            RUN: begin
                rp_ready = !out_valid || out_ready;
                if (rp_hs && node_cnt == target - NODE_W'(1)) state_nxt = FLUSH;
            end
            FLUSH: if (!out_valid || out_ready) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            target      <= '0;
            node_cnt    <= '0;
            prev        <= '0;
            out_node_id <= '0;
            out_degree  <= '0;
            out_valid   <= 1'b0;
            err_nonmono <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                target      <= num_nodes;
                node_cnt    <= '0;
                err_nonmono <= 1'b0;
            end
            if (state == FIRST && rp_hs) prev <= rp_data;
            // A new beat overwrites the register even when the old one is handed off this cycle
            if (load) begin
                out_node_id <= node_cnt;
                out_degree  <= beat_degree;
                out_valid   <= 1'b1;
                prev        <= rp_data;
                node_cnt    <= node_cnt + NODE_W'(1);
                if (nonmono) err_nonmono <= 1'b1;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CSR_DEGREE_STATS_EN
    logic [DATA_W-1:0] stat_max;
    logic [NODE_W-1:0] stat_id;

    // Strict compare so ties keep the earlier node
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stat_max <= '0;
            stat_id  <= '0;
        end else if (load && beat_degree > stat_max) begin
            stat_max <= beat_degree;
            stat_id  <= node_cnt;
        end
    end

    assign max_degree  = stat_max;
    assign max_node_id = stat_id;
`else
    assign max_degree  = '0;
    assign max_node_id = '0;
`endif

endmodule

// File: tb/tb_csr_degree_streamer.sv
// tb/tb_csr_degree_streamer.sv - scoreboard bench for csr_degree_streamer
module tb_csr_degree_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] num_nodes;
    logic [31:0] rp_data;
    logic        rp_valid;
    logic        rp_ready;
    logic [23:0] out_node_id;
    logic [31:0] out_degree;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err_nonmono;
    logic [31:0] max_degree;
    logic [23:0] max_node_id;

    int checks = 0;
    int passes = 0;

    logic [31:0] rp_q[$];
    logic [55:0] exp_q[$];
    logic [31:0] w[$];

    csr_degree_streamer #(.DATA_W(32), .NODE_W(24)) dut (
        .clk(clk), .rst(rst), .start(start), .num_nodes(num_nodes),
        .rp_data(rp_data), .rp_valid(rp_valid), .rp_ready(rp_ready),
        .out_node_id(out_node_id), .out_degree(out_degree), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .err_nonmono(err_nonmono),
        .max_degree(max_degree), .max_node_id(max_node_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [23:0] n, input logic err_before);
        @(negedge clk);
        start     = 1'b1;
        num_nodes = n;
        #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("err_before_start", {63'd0, err_nonmono}, {63'd0, err_before});
    endtask

    task automatic run_pass(input logic [31:0] ws[$], input int n, input int mode,
                            input int mid_after, input int abort_after);
        logic        exp_err = 1'b0;
        logic [31:0] mx = '0;
        logic [23:0] mx_id = '0;
        logic [31:0] d;
        logic [23:0] s_id = '0;
        logic [31:0] s_deg = '0;
        int          cyc = 0;
        int          hs = 0;
        int          last_hs = -1;
        bit          fired = 0;
        bit          stall = 0;
        exp_q.delete();
        rp_q = ws;
        for (int i = 0; i < n; i++) begin
            d = (ws[i+1] < ws[i]) ? 32'd0 : ws[i+1] - ws[i];
            if (ws[i+1] < ws[i]) exp_err = 1'b1;
            exp_q.push_back({24'(i), d});
            if (d > mx) begin
                mx    = d;
                mx_id = 24'(i);
            end
        end
        while (cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (mid_after >= 0 && !fired && hs == mid_after) begin
                start     = 1'b1;
                num_nodes = 24'd7;
                fired     = 1;
            end
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'b0;
            rp_valid  = rp_q.size() > 0;
            rp_data   = (rp_q.size() > 0) ? rp_q[0] : 32'd0;
            #1;
            if (stall)
                chk("hold", {7'd0, out_valid, out_node_id, out_degree}, {7'd0, 1'b1, s_id, s_deg});
            stall = out_valid && !out_ready;
            s_id  = out_node_id;
            s_deg = out_degree;
            if (stall) chk("stall_rp_ready", {63'd0, rp_ready}, 64'd0);
            if (rp_valid && rp_ready) void'(rp_q.pop_front());
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
                else chk("beat", {8'd0, out_node_id, out_degree}, {8'd0, exp_q.pop_front()});
                hs++;
                last_hs = cyc;
            end
            if (done) begin
                chk("beats_left", 64'(exp_q.size()), 64'd0);
                if (last_hs >= 0) chk("done_latency", 64'(cyc), 64'(last_hs + 1));
                chk("err_nonmono", {63'd0, err_nonmono}, {63'd0, exp_err});
                chk("rp_left", 64'(rp_q.size()), 64'(ws.size() - (n + 1)));
`ifdef CSR_DEGREE_STATS_EN
                chk("max_degree", {32'd0, max_degree}, {32'd0, mx});
                chk("max_node_id", {40'd0, max_node_id}, {40'd0, mx_id});
`else
                chk("stats_tied", {8'd0, max_degree, max_node_id}, 64'd0);
`endif
                rp_valid = 1'b0;
                return;
            end
            cyc++;
            if (abort_after > 0 && cyc == abort_after) return;
        end
        chk("timeout", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_nodes = '0; rp_data = '0; rp_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctl", {59'd0, rp_ready, out_valid, busy, done, err_nonmono}, 64'd0);
        chk("rst_out", {8'd0, out_node_id, out_degree}, 64'd0);
        chk("rst_stats", {8'd0, max_degree, max_node_id}, 64'd0);
        rst = 1'b0;

        w = '{32'd0, 32'd3, 32'd3, 32'd10, 32'd110};
        do_start(24'd4, 1'b0);
        run_pass(w, 4, 0, -1, 0);
        do_start(24'd4, 1'b0);
        run_pass(w, 4, 1, -1, 0);

        w = '{32'd5, 32'd77};
        do_start(24'd0, 1'b0);
        run_pass(w, 0, 0, -1, 0);

        w = '{32'd8, 32'd4, 32'd9};
        do_start(24'd2, 1'b0);
        run_pass(w, 2, 0, -1, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("err_sticky", {63'd0, err_nonmono}, 64'd1);

        w = '{32'd0, 32'd2, 32'd4, 32'd6};
        do_start(24'd3, 1'b1);
        run_pass(w, 3, 0, 2, 0);

        w = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
        do_start(24'd1, 1'b0);
        run_pass(w, 1, 0, -1, 0);

        w = '{32'd0, 32'd1, 32'd2, 32'd3};
        do_start(24'd3, 1'b0);
        run_pass(w, 3, 2, -1, 4);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_ctl", {59'd0, rp_ready, out_valid, busy, done, err_nonmono}, 64'd0);
        chk("midrst_out", {8'd0, out_node_id, out_degree}, 64'd0);
        chk("midrst_stats", {8'd0, max_degree, max_node_id}, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("no_done_after_rst", {62'd0, done, busy}, 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
